// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// FSM states and op-class decode helpers.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MADD  = 3'b100;
    localparam logic [2:0] MD_MADDU = 3'b101;
    localparam logic [2:0] MD_MSUB  = 3'b110;
    localparam logic [2:0] MD_MSUBU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // Even op codes are the signed variants.
    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iteration datapath shared by multiply and divide: one 2*WIDTH shift
// register, one WIDTH-bit operand register, one adder and a down counter.
// Multiply: shift-add, low half starts as the multiplier.
// Divide:   restoring division, low half starts as the dividend,
//           upper half ends as remainder and lower half as quotient.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mode,      // 1 = divide, 0 = multiply
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mode_q, mode_d;

    logic [WIDTH:0]     x_s;
    logic [WIDTH+1:0]   addend_s;
    logic [WIDTH+1:0]   sum_s;
    logic               qbit_s;

    // Single adder: add the multiplicand, or subtract the divisor as a trial.
    always_comb begin
        x_s      = mode_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        addend_s = mode_q ? ~{2'b00, m_q} : {2'b00, m_q};
        sum_s    = {1'b0, x_s} + addend_s + {{(WIDTH+1){1'b0}}, mode_q};
        qbit_s   = ~sum_s[WIDTH+1];
    end

    // Next-state for the shift register, operand register and counter.
    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (load) begin
            mode_d = mode;
            m_d    = mode ? b_mag : a_mag;
            acc_d  = {{WIDTH{1'b0}}, (mode ? a_mag : b_mag)};
            cnt_d  = CW'(WIDTH - 1);
        end else if (step) begin
            if (mode_q) begin
                acc_d = {(qbit_s ? sum_s[WIDTH-1:0] : x_s[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], qbit_s};
            end else if (acc_q[0]) begin
                acc_d = {sum_s[WIDTH:0], acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
            if (cnt_q != {CW{1'b0}}) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= {(2*WIDTH){1'b0}};
            m_q    <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV/MADD/MSUB unit with start/busy/done handshake and
// synchronous flush. Holds the FSM, sign handling and accumulation; the
// iterative core lives in muldiv_iter.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   hilo_i,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    md_state_e          state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               dbz_op_q, dbz_op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               accept_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [2*WIDTH-1:0] iter_acc_s;
    logic               iter_last_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;
    logic [2*WIDTH-1:0] fin_s;

    // Operand signs and magnitudes as seen at the start of an operation.
    always_comb begin
        a_neg_s = is_signed(op) & a[WIDTH-1];
        b_neg_s = is_signed(op) & b[WIDTH-1];
        a_mag_s = a_neg_s ? (-a) : a;
        b_mag_s = b_neg_s ? (-b) : b;
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_s),
        .step  (state_q == ST_CALC),
        .mode  (is_div(op)),
        .a_mag (a_mag_s),
        .b_mag (b_mag_s),
        .acc   (iter_acc_s),
        .last  (iter_last_s)
    );

    // Final result: sign correction, then accumulation or divide packing.
    // MIN / -1 needs no special case: the magnitude quotient 2^(WIDTH-1)
    // negates back to itself and the remainder is zero.
    always_comb begin
        prod_s = (sign_a_q ^ sign_b_q) ? (-iter_acc_s) : iter_acc_s;
        quot_s = (sign_a_q ^ sign_b_q) ? (-iter_acc_s[WIDTH-1:0]) : iter_acc_s[WIDTH-1:0];
        rem_s  = sign_a_q ? (-iter_acc_s[2*WIDTH-1:WIDTH]) : iter_acc_s[2*WIDTH-1:WIDTH];
        if (dbz_op_q) begin
            fin_s = {a_q, {WIDTH{1'b1}}};
        end else if (is_div(op_q)) begin
            fin_s = {rem_s, quot_s};
        end else if (is_acc(op_q)) begin
            if (is_sub(op_q)) begin
                fin_s = hilo_q - prod_s;
            end else begin
                fin_s = hilo_q + prod_s;
            end
        end else begin
            fin_s = prod_s;
        end
    end

    // FSM next state, operand latching and registered output values.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        hilo_d   = hilo_q;
        a_d      = a_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_op_d = dbz_op_q;
        result_d = result_q;
        accept_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !flush;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_CALC: state_d = iter_last_s ? ST_FIN : ST_CALC;
            ST_FIN: begin
                state_d  = ST_DONE;
                result_d = fin_s;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept_s) begin
            op_d     = op;
            hilo_d   = hilo_i;
            a_d      = a;
            sign_a_d = a_neg_s;
            sign_b_d = b_neg_s;
            dbz_op_d = is_div(op) && (b == {WIDTH{1'b0}});
            state_d  = (is_div(op) && (b == {WIDTH{1'b0}})) ? ST_FIN : ST_CALC;
        end else begin
            op_d = op_q;
        end

        // Flush cancels everything in flight, including a same-cycle start.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end else begin
            result_d = result_d;
        end

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIN);
        done_d = (state_d == ST_DONE);
        dbz_d  = (state_d == ST_DONE) && dbz_op_q;
    end

    // Control, latched-operand and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            hilo_q   <= {(2*WIDTH){1'b0}};
            a_q      <= {WIDTH{1'b0}};
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_op_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            hilo_q   <= hilo_d;
            a_q      <= a_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_op_q <= dbz_op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result      = result_q;

endmodule
